// File: rtl/mbist_march_controller.sv
// March C- memory BIST engine driving a single-port RAM.
// Walks six March elements over every address and compares read data
// against the expected background. Keeps the first failing location and a
// saturating mismatch count until the next accepted start.
module mbist_march_controller #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp,
  output logic [2:0]        fail_elem,
  output logic [CNT_W-1:0]  err_count,
  output logic              we,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramin,
  input  logic [DATA_W-1:0] ramout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_CHECK    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] D0        = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] D1        = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        WAIT_LAST = 8'(RD_LAT - 2);
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  // Elements E3 and E4 walk from the top address down to zero.
  function automatic logic elem_is_down(input logic [2:0] e);
    case (e)
      3'd3, 3'd4: elem_is_down = 1'b1;
      default:    elem_is_down = 1'b0;
    endcase
  endfunction

  // Background each element expects to read back (E2 and E4 read ones).
  function automatic logic [DATA_W-1:0] elem_rd_val(input logic [2:0] e);
    case (e)
      3'd2, 3'd4: elem_rd_val = D1;
      default:    elem_rd_val = D0;
    endcase
  endfunction

  // Background each element writes after its read (E1 and E3 write ones).
  function automatic logic [DATA_W-1:0] elem_wr_val(input logic [2:0] e);
    case (e)
      3'd1, 3'd3: elem_wr_val = D1;
      default:    elem_wr_val = D0;
    endcase
  endfunction

  state_t            state_q;
  logic [2:0]        elem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wait_q;
  logic              busy_q, done_q, fail_q, we_q;
  logic [ADDR_W-1:0] fail_addr_q, ramaddr_q;
  logic [DATA_W-1:0] fail_data_q, fail_exp_q, ramin_q;
  logic [2:0]        fail_elem_q;
  logic [CNT_W-1:0]  err_count_q;

  logic [DATA_W-1:0] exp_val_d;
  logic              mismatch_d;
  logic              last_addr_d;
  logic [ADDR_W-1:0] step_addr_d;
  logic [2:0]        next_elem_d;
  logic [ADDR_W-1:0] first_addr_d;
  logic              chk_we_d;
  logic [DATA_W-1:0] chk_din_d;

  // Address stepping, expected data and the write that accompanies a check.
  always_comb begin
    exp_val_d   = elem_rd_val(elem_q);
    mismatch_d  = (ramout != exp_val_d);
    next_elem_d = elem_q + 3'd1;
    if (elem_is_down(elem_q)) begin
      last_addr_d = (addr_q == ADDR_ZERO);
      step_addr_d = addr_q - ADDR_ONE;
    end else begin
      last_addr_d = (addr_q == ADDR_MAX);
      step_addr_d = addr_q + ADDR_ONE;
    end
    if (elem_is_down(next_elem_d)) begin
      first_addr_d = ADDR_MAX;
    end else begin
      first_addr_d = ADDR_ZERO;
    end
    // E5 is read-only; every other read element writes in its check cycle.
    if (elem_q != ELEM_LAST) begin
      chk_we_d  = 1'b1;
      chk_din_d = elem_wr_val(elem_q);
    end else begin
      chk_we_d  = 1'b0;
      chk_din_d = D0;
    end
  end

  // March sequencer with registered RAM-side and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= ADDR_ZERO;
      wait_q      <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= ADDR_ZERO;
      fail_data_q <= D0;
      fail_exp_q  <= D0;
      fail_elem_q <= 3'd0;
      err_count_q <= CNT_ZERO;
      we_q        <= 1'b0;
      ramaddr_q   <= ADDR_ZERO;
      ramin_q     <= D0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          we_q    <= 1'b0;
          ramin_q <= D0;
          if (start) begin
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= ADDR_ZERO;
            fail_data_q <= D0;
            fail_exp_q  <= D0;
            fail_elem_q <= 3'd0;
            err_count_q <= CNT_ZERO;
            elem_q      <= 3'd0;
            addr_q      <= ADDR_ZERO;
            ramaddr_q   <= ADDR_ZERO;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // The first WRITE cycle only primes the port; writes follow.
          if (!we_q) begin
            we_q      <= 1'b1;
            ramaddr_q <= addr_q;
            ramin_q   <= D0;
          end else if (addr_q == ADDR_MAX) begin
            we_q      <= 1'b0;
            ramin_q   <= D0;
            elem_q    <= 3'd1;
            addr_q    <= ADDR_ZERO;
            ramaddr_q <= ADDR_ZERO;
            state_q   <= S_RD_ISSUE;
          end else begin
            we_q      <= 1'b1;
            ramin_q   <= D0;
            addr_q    <= addr_q + ADDR_ONE;
            ramaddr_q <= addr_q + ADDR_ONE;
          end
        end
        S_RD_ISSUE: begin
          if (RD_LAT > 1) begin
            wait_q  <= 8'd0;
            we_q    <= 1'b0;
            ramin_q <= D0;
            state_q <= S_RD_WAIT;
          end else begin
            we_q    <= chk_we_d;
            ramin_q <= chk_din_d;
            state_q <= S_CHECK;
          end
        end
        S_RD_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            we_q    <= chk_we_d;
            ramin_q <= chk_din_d;
            state_q <= S_CHECK;
          end else begin
            wait_q  <= wait_q + 8'd1;
          end
        end
        S_CHECK: begin
          if (mismatch_d) begin
            if (err_count_q != CNT_MAX) begin
              err_count_q <= err_count_q + CNT_ONE;
            end
            // Only the first mismatch of a run is captured.
            if (!fail_q) begin
              fail_q      <= 1'b1;
              fail_addr_q <= addr_q;
              fail_data_q <= ramout;
              fail_exp_q  <= exp_val_d;
              fail_elem_q <= elem_q;
            end
          end
          we_q    <= 1'b0;
          ramin_q <= D0;
          if (last_addr_d) begin
            if (elem_q == ELEM_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              elem_q    <= next_elem_d;
              addr_q    <= first_addr_d;
              ramaddr_q <= first_addr_d;
              state_q   <= S_RD_ISSUE;
            end
          end else begin
            addr_q    <= step_addr_d;
            ramaddr_q <= step_addr_d;
            state_q   <= S_RD_ISSUE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
          ramin_q <= D0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_exp  = fail_exp_q;
  assign fail_elem = fail_elem_q;
  assign err_count = err_count_q;
  assign we        = we_q;
  assign ramaddr   = ramaddr_q;
  assign ramin     = ramin_q;

endmodule

// File: tb/tb_mbist_march_controller.sv
// Directed bench for mbist_march_controller with a registered-read RAM model
// that can hold one stuck-at fault. Expected write traffic and per-run
// results are queued when a run is launched and consumed as the DUT works.
module tb_mbist_march_controller;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, fail, we;
  logic [5:0] fail_addr, ramaddr;
  logic [7:0] fail_data, fail_exp, err_count, ramin;
  logic [2:0] fail_elem;
  logic [7:0] ramout;

  logic [7:0] mem [0:N-1];
  logic [5:0] flt_addr = 6'd0;
  logic [7:0] flt_and = 8'hFF;
  logic [7:0] flt_or = 8'h00;

  typedef struct {
    logic       fail;
    logic [5:0] fa;
    logic [7:0] fd;
    logic [7:0] fe;
    logic [2:0] el;
    logic [7:0] ec;
  } res_t;
  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  res_t res_q[$];
  wr_t  wr_q[$];
  int   n_checks = 0;
  int   n_fails = 0;

  mbist_march_controller #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_data(fail_data),
    .fail_exp(fail_exp), .fail_elem(fail_elem), .err_count(err_count),
    .we(we), .ramaddr(ramaddr), .ramin(ramin), .ramout(ramout)
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read of the old contents, optional stuck bits.
  always @(posedge clk) begin
    if (we === 1'b1) begin
      mem[ramaddr] <= (ramaddr == flt_addr) ? ((ramin & flt_and) | flt_or) : ramin;
    end
    ramout <= mem[ramaddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [5:0] fa, input logic [7:0] am, input logic [7:0] om,
                     input res_t exp_r, input int ign_at, input int abort_at);
    int         cycles;
    int         nwr;
    logic       prev_we;
    logic [5:0] prev_addr;
    logic       aborted;
    wr_t        w;
    res_t       r;
    flt_addr = fa;
    flt_and  = am;
    flt_or   = om;
    res_q.push_back(exp_r);
    for (int e = 0; e < 5; e++) begin
      for (int i = 0; i < N; i++) begin
        w.a = (e == 3 || e == 4) ? 6'(N - 1 - i) : 6'(i);
        w.d = (e == 1 || e == 3) ? 8'hFF : 8'h00;
        wr_q.push_back(w);
      end
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    cycles    = 0;
    nwr       = 0;
    aborted   = 1'b0;
    prev_we   = we;
    prev_addr = ramaddr;
    while (done !== 1'b1 && cycles < 2000 && !aborted) begin
      @(posedge clk);
      #1;
      cycles++;
      start = 1'b0;
      if (cycles == ign_at) start = 1'b1;
      if (we === 1'b1) begin
        if (wr_q.size() == 0) begin
          check("wr_count_overrun", 32'(nwr + 1), 32'(5 * N));
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(ramaddr), 32'(w.a));
          check("wr_data", 32'(ramin), 32'(w.d));
          if (nwr >= N) begin
            check("rd_before_wr_addr", 32'(prev_addr), 32'(ramaddr));
            check("rd_before_wr_we", 32'(prev_we), 32'd0);
          end
        end
        nwr++;
      end
      if (abort_at > 0 && cycles >= abort_at && we === 1'b1) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_we", 32'(we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ramaddr", 32'(ramaddr), 32'd0);
        check("abort_err_count", 32'(err_count), 32'd0);
        aborted = 1'b1;
      end
      prev_we   = we;
      prev_addr = ramaddr;
    end
    if (aborted) begin
      wr_q.delete();
      r = res_q.pop_front();
      #3 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_abort_busy", 32'(busy), 32'd0);
      check("post_abort_done", 32'(done), 32'd0);
    end else begin
      r = res_q.pop_front();
      check("cycles_to_done", 32'(cycles), 32'd705);
      check("busy_at_done", 32'(busy), 32'd0);
      check("we_at_done", 32'(we), 32'd0);
      check("fail", 32'(fail), 32'(r.fail));
      check("fail_addr", 32'(fail_addr), 32'(r.fa));
      check("fail_data", 32'(fail_data), 32'(r.fd));
      check("fail_exp", 32'(fail_exp), 32'(r.fe));
      check("fail_elem", 32'(fail_elem), 32'(r.el));
      check("err_count", 32'(err_count), 32'(r.ec));
      check("write_pulses", 32'(nwr), 32'(5 * N));
      check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("done_held", 32'(done), 32'd1);
    end
  endtask

  initial begin
    res_t clean_r, f1_r, f2_r;
    clean_r = '{fail: 1'b0, fa: 6'h00, fd: 8'h00, fe: 8'h00, el: 3'd0, ec: 8'd0};
    f1_r    = '{fail: 1'b1, fa: 6'h15, fd: 8'h01, fe: 8'h00, el: 3'd1, ec: 8'd3};
    f2_r    = '{fail: 1'b1, fa: 6'h3F, fd: 8'h7F, fe: 8'hFF, el: 3'd2, ec: 8'd2};

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_fail_data", 32'(fail_data), 32'd0);
    check("rst_fail_exp", 32'(fail_exp), 32'd0);
    check("rst_fail_elem", 32'(fail_elem), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_ramaddr", 32'(ramaddr), 32'd0);
    check("rst_ramin", 32'(ramin), 32'd0);
    #10 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_we", 32'(we), 32'd0);

    // Fault-free run.
    run(6'h00, 8'hFF, 8'h00, clean_r, 0, 0);
    // Bit0 stuck-at-1 at 0x15.
    run(6'h15, 8'hFF, 8'h01, f1_r, 0, 0);
    // Bit7 stuck-at-0 at 0x3F.
    run(6'h3F, 8'h7F, 8'h00, f2_r, 0, 0);
    // Start pulse while busy must be ignored.
    run(6'h00, 8'hFF, 8'h00, clean_r, 100, 0);
    // Fault run aborted by reset during E3, then a clean rerun.
    run(6'h15, 8'hFF, 8'h01, f1_r, 0, 400);
    check("abort_fail_cleared", 32'(fail), 32'd0);
    run(6'h00, 8'hFF, 8'h00, clean_r, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mbist_march_controller.md
Name: mbist_march_controller

Overview:
- MBIST engine that acts as the initiator on the single-port RAM interface (we, ramaddr, ramin, ramout).
- Runs a March C- test over every address and compares read data against the expected background.
- Reports pass/fail, the first failing location, and an error count.
- Sits between the test-mode control logic and the RAM's port-side muxing.

Parameters:
ADDR_W, 6, RAM address width; depth N = 2**ADDR_W
DATA_W, 8, RAM data width
RD_LAT, 1, cycles from read address presented to ramout valid (RAM output is registered)
CNT_W, 8, err_count width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins test when idle
busy  out  1  high while test is running
done  out  1  high once test completes; held until next accepted start
fail  out  1  sticky mismatch flag; cleared on accepted start
fail_addr  out  ADDR_W  address of first mismatch
fail_data  out  DATA_W  ramout value at first mismatch
fail_exp  out  DATA_W  expected value at first mismatch
fail_elem  out  3  March element index (0-5) of first mismatch
err_count  out  CNT_W  total mismatching reads, saturating at all-ones
we  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramin  out  DATA_W  RAM write data
ramout  in  DATA_W  RAM read data

Behaviour:
- Reset (async, rst_n=0): every output goes to 0 immediately, FSM goes to IDLE. Asserting reset mid-test aborts the test with no partial result kept.
- Backgrounds: D0 = all zeros, D1 = all ones.
- March C- elements:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
- "up" walks addresses 0 to N-1; "down" walks N-1 to 0.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, CHECK, DONE.
  - IDLE/DONE + start=1: clear fail, fail_*, err_count and done; set busy next cycle; element=0, addr=0; go to WRITE.
  - start while busy is ignored.
  - WRITE (E0 only, 1 cycle per address): we=1, ramin=D0. At the last address, advance to E1.
  - RD_ISSUE: we=0, ramaddr=addr. Go to RD_WAIT if RD_LAT>1, else go to CHECK.
  - RD_WAIT: hold the address for RD_LAT-1 cycles, then go to CHECK.
  - CHECK: compare ramout against the expected value for the element.
    - On mismatch: increment err_count (saturating).
    - On the first mismatch only: set fail=1 and latch fail_addr, fail_data, fail_exp, fail_elem. Later mismatches do not overwrite these.
    - In the same cycle for E1-E4: drive we=1, ramaddr=addr, ramin = the element's write value.
    - Then step the address, or advance the element at the end address.
    - For E5, CHECK writes nothing.
- After the final E5 CHECK: next cycle busy=0, done=1, state goes to DONE, we=0.
- Outputs are registered; the test never stops early on a failure.
- Cycles from the accepted-start edge to done=1: N*(1+5*(1+RD_LAT))+1 = 705 for the defaults.
- Outside WRITE and CHECK, we=0 and ramin=0.
- ramaddr changes only when an address or element advances.
- Address wrap: an up-walk ends at N-1 and a down-walk ends at 0. No counter overflow escapes onto ramaddr.

Test Plan:
1. Reset: rst_n=0 mid-cycle → all outputs 0 asynchronously. Release and wait 10 cycles → busy=0, done=0, we=0.
2. Fault-free RAM model (RD_LAT=1), pulse start → busy next cycle. done=1 exactly 705 cycles after the start edge, with fail=0 and err_count=0. Write count = 64+4*64 = 320 we pulses.
3. RAM model with bit0 stuck-at-1 at addr 0x15 → fail=1, fail_elem=1, fail_addr=0x15, fail_exp=0x00, fail_data=0x01, err_count=3 (reads in E1, E3, E5).
4. Bit7 stuck-at-0 at addr 0x3F → fail_elem=2, fail_addr=0x3F, fail_exp=0xFF, fail_data=0x7F, err_count=2 (E2, E4).
5. Second start pulse while busy → ignored, run completes in 705 cycles. Assert rst_n low during E3 → we=0 and busy=0 at once. New start → full 705-cycle clean run with fail cleared.
6. Address-order monitor:
   - E3 and E4 present ramaddr 0x3F down to 0x00; E0-E2 and E5 present 0x00 up to 0x3F.
   - Each read is followed by a write to the same address one cycle later for RD_LAT=1, or RD_LAT cycles later for RD_LAT=2.
